// File: rtl/decode_stage.sv
// MIPS-subset decode stage: decodes one instruction per cycle into a registered ID/EX slot.
// Optional DECODE_WB_BYPASS_EN forwards same-cycle writeback data into captured operands.
module decode_stage #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32,
   parameter int unsigned PC_W  = 7,
   localparam int unsigned AW   = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [PC_W-1:0] in_pc,
   input  logic            flush,
   input  logic            wb_en,
   input  logic [AW-1:0]   wb_addr,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [PC_W-1:0] out_pc,
   output logic [XLEN-1:0] out_rs_val,
   output logic [XLEN-1:0] out_rt_val,
   output logic [XLEN-1:0] out_imm,
   output logic [4:0]      out_shamt,
   output logic [AW-1:0]   out_dst,
   output logic [PC_W-1:0] out_jtarget,
   output logic [2:0]      out_alu_ctrl,
   output logic            out_alu_src,
   output logic            out_mem_read,
   output logic            out_mem_write,
   output logic            out_mem_to_reg,
   output logic            out_reg_write,
   output logic            out_branch,
   output logic            out_jump,
   output logic            out_jr,
   output logic            out_illegal
);

   typedef struct packed {
      logic [2:0] alu_ctrl;
      logic       alu_src;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_write;
      logic       branch;
      logic       jump;
      logic       jr;
      logic       illegal;
   } ctrl_t;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpAndi  = 6'b001100;
   localparam logic [5:0] OpOri   = 6'b001101;
   localparam logic [5:0] OpXori  = 6'b001110;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBgt   = 6'b000111;
   localparam logic [5:0] OpJ     = 6'b000010;

   localparam logic [5:0] FnAdd = 6'b100000;
   localparam logic [5:0] FnSub = 6'b100010;
   localparam logic [5:0] FnAnd = 6'b100100;
   localparam logic [5:0] FnOr  = 6'b100101;
   localparam logic [5:0] FnXor = 6'b100110;
   localparam logic [5:0] FnSlt = 6'b101010;
   localparam logic [5:0] FnSll = 6'b000000;
   localparam logic [5:0] FnJr  = 6'b001000;

   logic [5:0]      op, fn;
   logic [AW-1:0]   rs_a, rt_a, rd_a, dst_d;
   logic            rt_src;
   ctrl_t           ctrl_d, ctrl_q;
   logic [XLEN-1:0] rs_rd, rt_rd;
   logic            hazard, accept;

   logic [XLEN-1:0] rf_q [NREGS];
   logic            valid_q;
   logic [PC_W-1:0] pc_q, jtarget_q;
   logic [XLEN-1:0] rs_val_q, rt_val_q, imm_q;
   logic [4:0]      shamt_q;
   logic [AW-1:0]   dst_q, rs_q, rt_q;

   assign op   = in_instr[31:26];
   assign fn   = in_instr[5:0];
   assign rs_a = in_instr[21 +: AW];
   assign rt_a = in_instr[16 +: AW];
   assign rd_a = in_instr[11 +: AW];

   always_comb begin
      ctrl_d = '0;
      dst_d  = '0;
      rt_src = 1'b0;
      case (op)
         OpRtype: begin
            rt_src = 1'b1;
            dst_d  = rd_a;
            ctrl_d.reg_write = 1'b1;
            case (fn)
               FnAdd:   ctrl_d.alu_ctrl = 3'b001;
               FnSub:   ctrl_d.alu_ctrl = 3'b101;
               FnAnd:   ctrl_d.alu_ctrl = 3'b011;
               FnOr:    ctrl_d.alu_ctrl = 3'b100;
               FnXor:   ctrl_d.alu_ctrl = 3'b000;
               FnSlt:   ctrl_d.alu_ctrl = 3'b110;
               FnSll:   ctrl_d.alu_ctrl = 3'b111;
               FnJr: begin
                  ctrl_d.jr        = 1'b1;
                  ctrl_d.reg_write = 1'b0;
               end
               default: ctrl_d.illegal = 1'b1;
            endcase
         end
         OpAddi, OpAndi, OpOri, OpXori: begin
            dst_d            = rt_a;
            ctrl_d.alu_src   = 1'b1;
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_ctrl  = (op == OpAddi) ? 3'b001 :
                               (op == OpAndi) ? 3'b011 :
                               (op == OpOri)  ? 3'b100 : 3'b000;
         end
         OpLw: begin
            dst_d             = rt_a;
            ctrl_d.alu_ctrl   = 3'b001;
            ctrl_d.alu_src    = 1'b1;
            ctrl_d.mem_read   = 1'b1;
            ctrl_d.mem_to_reg = 1'b1;
            ctrl_d.reg_write  = 1'b1;
         end
         OpSw: begin
            rt_src           = 1'b1;
            ctrl_d.alu_ctrl  = 3'b001;
            ctrl_d.alu_src   = 1'b1;
            ctrl_d.mem_write = 1'b1;
         end
         OpBgt: begin
            rt_src          = 1'b1;
            ctrl_d.alu_ctrl = 3'b010;
            ctrl_d.branch   = 1'b1;
         end
         OpJ:     ctrl_d.jump = 1'b1;
         default: ctrl_d.illegal = 1'b1;
      endcase
      if (ctrl_d.illegal) begin
         ctrl_d.reg_write  = 1'b0;
         ctrl_d.mem_read   = 1'b0;
         ctrl_d.mem_write  = 1'b0;
         ctrl_d.mem_to_reg = 1'b0;
         ctrl_d.branch     = 1'b0;
         ctrl_d.jump       = 1'b0;
         ctrl_d.jr         = 1'b0;
      end
      if (dst_d == '0) ctrl_d.reg_write = 1'b0;
   end

   always_comb begin
      rs_rd = (rs_a == '0) ? '0 : rf_q[rs_a];
      rt_rd = (rt_a == '0) ? '0 : rf_q[rt_a];
`ifdef DECODE_WB_BYPASS_EN
      if (wb_en && (wb_addr != '0)) begin
         if (wb_addr == rs_a) rs_rd = wb_data;
         if (wb_addr == rt_a) rt_rd = wb_data;
      end
`endif
   end

   // Slot holds an LW whose result the incoming instruction needs: stall one cycle.
   assign hazard = valid_q && ctrl_q.mem_read && (dst_q != '0) &&
                   ((rs_a == dst_q) || (rt_src && (rt_a == dst_q)));
   assign in_ready = !flush && !hazard && (!valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NREGS); i++) rf_q[i] <= '0;
         valid_q    <= 1'b0;
         ctrl_q     <= '0;
         pc_q       <= '0;
         jtarget_q  <= '0;
         rs_val_q   <= '0;
         rt_val_q   <= '0;
         imm_q      <= '0;
         shamt_q    <= '0;
         dst_q      <= '0;
         rs_q       <= '0;
         rt_q       <= '0;
      end else begin
         if (wb_en && (wb_addr != '0)) rf_q[wb_addr] <= wb_data;
         if (flush) begin
            valid_q <= 1'b0;
         end else if (accept) begin
            valid_q   <= 1'b1;
            ctrl_q    <= ctrl_d;
            pc_q      <= in_pc;
            jtarget_q <= in_instr[PC_W-1:0];
            rs_val_q  <= rs_rd;
            rt_val_q  <= rt_rd;
            imm_q     <= {{(XLEN-16){in_instr[15]}}, in_instr[15:0]};
            shamt_q   <= in_instr[10:6];
            dst_q     <= dst_d;
            rs_q      <= rs_a;
            rt_q      <= rt_a;
         end else if (valid_q) begin
            if (out_ready) valid_q <= 1'b0;
            // Keep held operands coherent with the register file.
            if (wb_en && (wb_addr != '0)) begin
               if (wb_addr == rs_q) rs_val_q <= wb_data;
               if (wb_addr == rt_q) rt_val_q <= wb_data;
            end
         end
      end
   end

   assign out_valid      = valid_q;
   assign out_pc         = pc_q;
   assign out_rs_val     = rs_val_q;
   assign out_rt_val     = rt_val_q;
   assign out_imm        = imm_q;
   assign out_shamt      = shamt_q;
   assign out_dst        = dst_q;
   assign out_jtarget    = jtarget_q;
   assign out_alu_ctrl   = ctrl_q.alu_ctrl;
   assign out_alu_src    = ctrl_q.alu_src;
   assign out_mem_read   = ctrl_q.mem_read;
   assign out_mem_write  = ctrl_q.mem_write;
   assign out_mem_to_reg = ctrl_q.mem_to_reg;
   assign out_reg_write  = ctrl_q.reg_write;
   assign out_branch     = ctrl_q.branch;
   assign out_jump       = ctrl_q.jump;
   assign out_jr         = ctrl_q.jr;
   assign out_illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus random traffic checked by a scoreboard.
module tb_decode_stage;
   localparam int XLEN = 32, NREGS = 32, PC_W = 7, AW = 5;
`ifdef DECODE_WB_BYPASS_EN
   localparam logic [31:0] BYP_EXP = 32'h0000_0055;
`else
   localparam logic [31:0] BYP_EXP = 32'h0000_0011;
`endif

   typedef struct {
      logic [6:0]  pc, jt;
      logic [31:0] rs_val, rt_val, imm;
      logic [4:0]  rs, rt, shamt, dst;
      logic [2:0]  alu;
      logic        alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch, jump, jr, illegal;
      logic        rt_src, dst_known, alu_known, src_known;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n, in_valid, in_ready, flush, wb_en, out_valid, out_ready;
   logic [31:0] in_instr, wb_data, out_rs_val, out_rt_val, out_imm;
   logic [6:0] in_pc, out_pc, out_jtarget;
   logic [4:0] wb_addr, out_shamt, out_dst;
   logic [2:0] out_alu_ctrl;
   logic out_alu_src, out_mem_read, out_mem_write, out_mem_to_reg, out_reg_write;
   logic out_branch, out_jump, out_jr, out_illegal;

   always #5 clk = ~clk;

   decode_stage #(.XLEN(XLEN), .NREGS(NREGS), .PC_W(PC_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .in_pc(in_pc), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rs_val(out_rs_val),
      .out_rt_val(out_rt_val), .out_imm(out_imm), .out_shamt(out_shamt), .out_dst(out_dst),
      .out_jtarget(out_jtarget), .out_alu_ctrl(out_alu_ctrl), .out_alu_src(out_alu_src),
      .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
      .out_mem_to_reg(out_mem_to_reg), .out_reg_write(out_reg_write), .out_branch(out_branch),
      .out_jump(out_jump), .out_jr(out_jr), .out_illegal(out_illegal)
   );

   int checks = 0, failures = 0;
   exp_t sbq[$];
   logic [31:0] mrf [32];
   logic model_valid;
   logic [4:0] model_lw_dst;
   int pc_ctr = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=0x%08h want=0x%08h t=%0t", name, got, want, $time);
      end
   endtask

   // Expected decode straight from the instruction tables.
   function automatic exp_t ref_decode(input logic [31:0] w);
      exp_t e;
      e = '{default: '0};
      e.rs = w[25:21]; e.rt = w[20:16]; e.shamt = w[10:6]; e.jt = w[6:0];
      e.imm = {{16{w[15]}}, w[15:0]};
      e.alu_known = 1'b1; e.src_known = 1'b1;
      if (w[31:26] == 6'h00) begin
         e.rt_src = 1'b1; e.dst = w[15:11]; e.dst_known = 1'b1; e.reg_write = 1'b1;
         case (w[5:0])
            6'h20: e.alu = 3'd1;
            6'h22: e.alu = 3'd5;
            6'h24: e.alu = 3'd3;
            6'h25: e.alu = 3'd4;
            6'h26: e.alu = 3'd0;
            6'h2A: e.alu = 3'd6;
            6'h00: e.alu = 3'd7;
            6'h08: begin e.jr = 1'b1; e.reg_write = 1'b0; e.alu_known = 1'b0; end
            default: e.illegal = 1'b1;
         endcase
      end else begin
         case (w[31:26])
            6'h08, 6'h0C, 6'h0D, 6'h0E: begin
               e.alu = (w[31:26] == 6'h08) ? 3'd1 : (w[31:26] == 6'h0C) ? 3'd3 :
                       (w[31:26] == 6'h0D) ? 3'd4 : 3'd0;
               e.alu_src = 1'b1; e.dst = e.rt; e.dst_known = 1'b1; e.reg_write = 1'b1;
            end
            6'h23: begin
               e.alu = 3'd1; e.alu_src = 1'b1; e.mem_read = 1'b1; e.mem_to_reg = 1'b1;
               e.reg_write = 1'b1; e.dst = e.rt; e.dst_known = 1'b1;
            end
            6'h2B: begin e.alu = 3'd1; e.alu_src = 1'b1; e.mem_write = 1'b1; e.rt_src = 1'b1; end
            6'h07: begin e.alu = 3'd2; e.branch = 1'b1; e.rt_src = 1'b1; end
            6'h02: begin e.jump = 1'b1; e.alu_known = 1'b0; e.src_known = 1'b0; end
            default: e.illegal = 1'b1;
         endcase
      end
      if (e.illegal) begin
         e.reg_write = 0; e.jr = 0;
         e.alu_known = 0; e.src_known = 0; e.dst_known = 0;
      end
      if (e.dst_known && e.dst == 5'd0) e.reg_write = 1'b0;
      return e;
   endfunction

   function automatic logic [31:0] rd_reg(input logic [4:0] a);
      return (a == 5'd0) ? 32'd0 : mrf[a];
   endfunction

   // Drive one cycle of inputs; the model advances at the negedge ahead of the next edge.
   task automatic drive(input logic v, input logic [31:0] ins, input logic fl, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd, input logic ordy,
                        output logic acc);
      exp_t e, h;
      logic haz, exp_rdy;
      in_valid = v; in_instr = ins; in_pc = pc_ctr[6:0]; flush = fl;
      wb_en = we; wb_addr = wa; wb_data = wd; out_ready = ordy;
      pc_ctr++;
      @(negedge clk);
      e = ref_decode(ins);
      e.pc = in_pc;
      haz = model_valid && (model_lw_dst != 0) &&
            (e.rs == model_lw_dst || (e.rt_src && e.rt == model_lw_dst));
      exp_rdy = !fl && !haz && (!model_valid || ordy);
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      chk("out_valid", {31'd0, out_valid}, {31'd0, model_valid});
      acc = v && exp_rdy;
      e.rs_val = rd_reg(e.rs);
      e.rt_val = rd_reg(e.rt);
`ifdef DECODE_WB_BYPASS_EN
      if (we && wa != 0) begin
         if (wa == e.rs) e.rs_val = wd;
         if (wa == e.rt) e.rt_val = wd;
      end
`endif
      if (fl) begin
         if (model_valid && !ordy && sbq.size() > 0) sbq.delete(0);
         model_valid = 1'b0;
      end else if (acc) begin
         sbq.push_back(e);
         model_valid = 1'b1;
         model_lw_dst = e.mem_read ? e.dst : 5'd0;
      end else if (model_valid) begin
         if (ordy) model_valid = 1'b0;
         else if (we && wa != 0 && sbq.size() > 0) begin
            h = sbq[0];
            if (h.rs == wa) h.rs_val = wd;
            if (h.rt == wa) h.rt_val = wd;
            sbq[0] = h;
         end
      end
      if (we && wa != 0) mrf[wa] = wd;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] gen_instr();
      logic [4:0] rs, rt, rd, sh;
      logic [31:0] r;
      logic [5:0] fns [8];
      int k;
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h00, 6'h08};
      rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7)); sh = 5'($urandom_range(0, 31));
      r = $urandom;
      k = $urandom_range(0, 19);
      case (k)
         0, 1, 2, 3, 4, 5, 6, 7: return {6'h00, rs, rt, rd, sh, fns[k]};
         8:  return {6'h08, rs, rt, r[15:0]};
         9:  return {6'h0C, rs, rt, r[15:0]};
         10: return {6'h0D, rs, rt, r[15:0]};
         11: return {6'h0E, rs, rt, r[15:0]};
         13: return {6'h2B, rs, rt, r[15:0]};
         14: return {6'h07, rs, rt, r[15:0]};
         15: return {6'h02, r[25:0]};
         16: return {r[31] ? 6'h3F : 6'h11, rs, rt, r[15:0]};
         17: return {6'h00, rs, rt, rd, sh, 6'h01};
         default: return {6'h23, rs, rt, r[15:0]};
      endcase
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sbq.size() == 0) begin
               checks++; failures++;
               $display("FAIL sb_orphan got=out_valid want=empty_slot t=%0t", $time);
            end else begin
               e = sbq.pop_front();
               chk("sb_pc", {25'd0, out_pc}, {25'd0, e.pc});
               chk("sb_rs_val", out_rs_val, e.rs_val);
               if (e.rt_src) chk("sb_rt_val", out_rt_val, e.rt_val);
               chk("sb_imm", out_imm, e.imm);
               chk("sb_shamt", {27'd0, out_shamt}, {27'd0, e.shamt});
               if (e.dst_known) chk("sb_dst", {27'd0, out_dst}, {27'd0, e.dst});
               chk("sb_jtarget", {25'd0, out_jtarget}, {25'd0, e.jt});
               if (e.alu_known) chk("sb_alu_ctrl", {29'd0, out_alu_ctrl}, {29'd0, e.alu});
               if (e.src_known) chk("sb_alu_src", {31'd0, out_alu_src}, {31'd0, e.alu_src});
               chk("sb_ctrl",
                   {23'd0, out_mem_read, out_mem_write, out_mem_to_reg, out_reg_write,
                    out_branch, out_jump, out_jr, out_illegal, 1'b0},
                   {23'd0, e.mem_read, e.mem_write, e.mem_to_reg, e.reg_write,
                    e.branch, e.jump, e.jr, e.illegal, 1'b0});
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

   initial begin : main
      logic acc;
      logic [6:0] pcv;
      logic [31:0] addr10 = {6'd0, 5'd9, 5'd0, 5'd10, 5'd0, 6'h20};
      rst_n = 1'b0; in_valid = 0; in_instr = 0; in_pc = 0; flush = 0;
      wb_en = 0; wb_addr = 0; wb_data = 0; out_ready = 0;
      for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
      model_valid = 1'b0; model_lw_dst = 5'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_rs_val", out_rs_val, 32'd0);
      chk("rst_imm", out_imm, 32'd0);
      chk("rst_ctrl", {24'd0, out_alu_ctrl, out_reg_write, out_alu_src, out_illegal,
                       out_jump, out_mem_read}, 32'd0);
      rst_n = 1'b1;

      // ADD r7,r5,r6
      drive(0, 0, 0, 1, 5'd5, 32'h11, 1, acc);
      drive(0, 0, 0, 1, 5'd6, 32'h22, 1, acc);
      drive(1, 32'h00A63820, 0, 0, 0, 0, 1, acc);
      chk("add_valid", {31'd0, out_valid}, 32'd1);
      chk("add_rs", out_rs_val, 32'h11);
      chk("add_rt", out_rt_val, 32'h22);
      chk("add_dst", {27'd0, out_dst}, 32'd7);
      chk("add_alu", {29'd0, out_alu_ctrl}, 32'd1);
      chk("add_rw", {31'd0, out_reg_write}, 32'd1);

      // ADDI r1,r0,-4 then an illegal opcode
      drive(1, 32'h2001FFFC, 0, 0, 0, 0, 1, acc);
      chk("addi_imm", out_imm, 32'hFFFF_FFFC);
      chk("addi_src", {31'd0, out_alu_src}, 32'd1);
      chk("addi_dst", {27'd0, out_dst}, 32'd1);
      drive(1, 32'hFC00_0000, 0, 0, 0, 0, 1, acc);
      chk("ill_flag", {31'd0, out_illegal}, 32'd1);
      chk("ill_ctrl", {27'd0, out_reg_write, out_mem_write, out_mem_read, out_jump, out_branch},
          32'd0);

      // LW r2,0(r3) then ADD r4,r2,r2: one bubble
      drive(1, 32'h8C62_0000, 0, 0, 0, 0, 1, acc);
      drive(1, 32'h0042_2020, 0, 0, 0, 0, 1, acc);
      chk("lu_bubble", {31'd0, out_valid}, 32'd0);
      drive(1, 32'h0042_2020, 0, 0, 0, 0, 1, acc);
      chk("lu_dep_valid", {31'd0, out_valid}, 32'd1);
      chk("lu_dep_dst", {27'd0, out_dst}, 32'd4);

      // Hold with snoop of rs
      drive(0, 0, 0, 1, 5'd9, 32'h1234, 1, acc);
      pcv = pc_ctr[6:0];
      drive(1, addr10, 0, 0, 0, 0, 0, acc);
      chk("hold_rs0", out_rs_val, 32'h1234);
      drive(0, 0, 0, 1, 5'd9, 32'hDEAD_BEEF, 0, acc);
      drive(0, 0, 0, 0, 0, 0, 0, acc);
      drive(0, 0, 0, 0, 0, 0, 0, acc);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_rs", out_rs_val, 32'hDEAD_BEEF);
      chk("hold_pc", {25'd0, out_pc}, {25'd0, pcv});
      chk("hold_dst", {27'd0, out_dst}, 32'd10);
      chk("hold_alu", {29'd0, out_alu_ctrl}, 32'd1);

      // Flush with in_valid and a valid slot
      drive(1, 32'h2001FFFC, 1, 0, 0, 0, 0, acc);
      chk("flush_empty", {31'd0, out_valid}, 32'd0);

      // Asynchronous reset mid-hold
      drive(1, 32'h2001FFFC, 0, 0, 0, 0, 0, acc);
      drive(0, 0, 0, 0, 0, 0, 0, acc);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_imm", out_imm, 32'd0);
      chk("arst_misc", {23'd0, out_pc, out_dst, out_alu_src, out_reg_write}, 32'd0);
      sbq.delete();
      model_valid = 1'b0; model_lw_dst = 5'd0;
      for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
      #1 rst_n = 1'b1;

      // Same-cycle writeback during accept
      drive(0, 0, 0, 1, 5'd5, 32'h11, 1, acc);
      drive(1, 32'h00A63820, 0, 1, 5'd5, 32'h55, 1, acc);
      chk("byp_rs", out_rs_val, BYP_EXP);

      for (int n = 0; n < 600; n++) begin
         drive($urandom_range(0, 3) != 0, gen_instr(), $urandom_range(0, 19) == 0,
               $urandom_range(0, 4) < 2, 5'($urandom_range(0, 7)), $urandom,
               $urandom_range(0, 9) < 7, acc);
      end
      repeat (3) drive(0, 0, 0, 0, 0, 0, 1, acc);
      chk("sb_drained", sbq.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
